// File: rtl/fifo_word_serializer_types.sv
// Shared types and default sizing for fifo_word_serializer: FSM states,
// bench-side error kinds and the error-report record.
package fifo_word_serializer_types;

    localparam int WIDTH_P = 8;
    localparam int DIV_P   = 4;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } ser_state_e;

    typedef enum logic [1:0] {
        INCORRECT_TX_BIT,
        YUMI_OUTSIDE_IDLE,
        RESET_DOES_NOT_IDLE_LINE
    } ser_err_e;

    typedef struct packed {
        ser_err_e    err;
        logic [63:0] stamp;
    } ser_err_rpt_s;

endpackage

// File: rtl/bit_tick_gen.sv
// Serial bit-period divider: pulses tick_o on the last clock of every bit
// and is held at zero while the serializer sits in IDLE.
module bit_tick_gen #(
    parameter int DIV_P = 4
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clear_i,
    output logic tick_o
);

    localparam int CNT_W = $clog2(DIV_P + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             w_last;

    // With DIV_P = 1 the counter never leaves zero, so every cycle is a boundary.
    assign w_last = (r_cnt == CNT_W'(DIV_P - 1));
    assign tick_o = w_last;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_cnt <= '0;
        end else if (clear_i || w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/fifo_word_serializer.sv
// Drains a valid/yumi FIFO port onto an async serial line (start, data LSB-first, stop).
// Define FIFO_WORD_SERIALIZER_PARITY_EN to insert an even-parity bit before the stop bit.
module fifo_word_serializer
    import fifo_word_serializer_types::*;
#(
    parameter int WIDTH_P = fifo_word_serializer_types::WIDTH_P,
    parameter int DIV_P   = fifo_word_serializer_types::DIV_P
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               valid_i,
    input  logic [WIDTH_P-1:0] data_i,
    output logic               yumi_o,
    output logic               tx_o,
    output logic               busy_o
);

    localparam int BIT_W    = $clog2(WIDTH_P + 1);
    localparam int NEXT_IDX = (WIDTH_P > 1) ? 1 : 0;

    ser_state_e         r_state;
    logic               r_tx;
    logic [WIDTH_P-1:0] r_shift;
    logic [BIT_W-1:0]   r_bit_cnt;
`ifdef FIFO_WORD_SERIALIZER_PARITY_EN
    logic               r_parity;
`endif
    logic               w_tick;
    logic               w_last_bit;

    bit_tick_gen #(
        .DIV_P (DIV_P)
    ) u_tick (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clear_i (r_state == IDLE),
        .tick_o  (w_tick)
    );

    // Dequeue is only offered in IDLE, and never while reset holds the FSM.
    assign yumi_o     = (r_state == IDLE) && valid_i && !reset_i;
    assign busy_o     = (r_state != IDLE);
    assign tx_o       = r_tx;
    assign w_last_bit = (r_bit_cnt == BIT_W'(WIDTH_P - 1));

    // NOTE: r_tx is assigned the value of the state being entered, so the line
    // is a pure flop output; all state uses <= so every branch sees pre-edge values.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state   <= IDLE;
            r_tx      <= 1'b1;
            r_shift   <= '0;
            r_bit_cnt <= '0;
`ifdef FIFO_WORD_SERIALIZER_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (valid_i) begin
                        r_state   <= START;
                        r_tx      <= 1'b0;
                        r_shift   <= data_i;
                        r_bit_cnt <= '0;
`ifdef FIFO_WORD_SERIALIZER_PARITY_EN
                        r_parity  <= ^data_i;
`endif
                    end
                end
                START: begin
                    if (w_tick) begin
                        r_state <= DATA;
                        r_tx    <= r_shift[0];
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        r_shift   <= r_shift >> 1;
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                        if (w_last_bit) begin
`ifdef FIFO_WORD_SERIALIZER_PARITY_EN
                            r_state <= PARITY;
                            r_tx    <= r_parity;
`else
                            r_state <= STOP;
                            r_tx    <= 1'b1;
`endif
                        end else begin
                            r_tx <= r_shift[NEXT_IDX];
                        end
                    end
                end
`ifdef FIFO_WORD_SERIALIZER_PARITY_EN
                PARITY: begin
                    if (w_tick) begin
                        r_state <= STOP;
                        r_tx    <= 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (w_tick) begin
                        r_state <= IDLE;
                        r_tx    <= 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule
